// File: rtl/i_execute_pkg.sv
// Shared EX-stage definitions: ALU op classes,
// funct codes, ALU control codes, multiply FSM states.
package i_execute_pkg;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
  localparam logic [1:0] AOP_ZERO  = 2'b11;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_MUL = 6'h18;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL,
    ALU_ZERO
  } alu_ctl_e;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_BUSY,
    MS_DONE
  } mul_state_e;

  function automatic alu_ctl_e alu_ctl(
    input logic [1:0] op,
    input logic [5:0] f
  );
    alu_ctl_e c;
    c = ALU_ZERO;
    unique case (1'b1)
      (op == AOP_ADD): c = ALU_ADD;
      (op == AOP_SUB): c = ALU_SUB;
      (op == AOP_FUNCT): begin
        case (f)
          F_ADD:   c = ALU_ADD;
          F_SUB:   c = ALU_SUB;
          F_AND:   c = ALU_AND;
          F_OR:    c = ALU_OR;
          F_SLT:   c = ALU_SLT;
          F_MUL:   c = ALU_MUL;
          default: c = ALU_ZERO;
        endcase
      end
      default: c = ALU_ZERO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i_execute_mul_unit.sv
// Iterative shift-add multiplier with a fixed
// WIDTH-cycle busy phase and start/busy/done handshake.
module mul_unit
  import i_execute_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e       r_state;
  mul_state_e       w_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_count;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MS_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: flush always returns to IDLE.
  always_comb begin
    w_next = r_state;
    if (i_flush) begin
      w_next = MS_IDLE;
    end else begin
      unique case (r_state)
        MS_IDLE: if (i_start) w_next = MS_BUSY;
        MS_BUSY: if (r_count == LAST) w_next = MS_DONE;
        MS_DONE: w_next = MS_IDLE;
        default: w_next = MS_IDLE;
      endcase
    end
  end

  // Outputs: stall covers the start cycle and BUSY.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    if (rst_n && !i_flush) begin
      unique case (r_state)
        MS_IDLE: o_busy = i_start;
        MS_BUSY: o_busy = 1'b1;
        MS_DONE: o_done = 1'b1;
        default: o_busy = 1'b0;
      endcase
    end
  end

  // Operand load and one shift-add step per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (r_state == MS_IDLE && i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_count  <= '0;
    end else if (r_state == MS_BUSY) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
    end
  end

  assign o_result = r_acc;

endmodule

// File: rtl/i_execute.sv
// MIPS EX stage: ALU control, operand/dest muxes,
// branch target, multiplier and the EX/MEM latch.
module i_execute
  import i_execute_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ID_EX_npc,
  input  logic [WIDTH-1:0] ID_EX_rdata1,
  input  logic [WIDTH-1:0] ID_EX_rdata2,
  input  logic [WIDTH-1:0] ID_EX_sign_ext,
  input  logic [4:0]       ID_EX_instr_2016,
  input  logic [4:0]       ID_EX_instr_1511,
  input  logic [1:0]       ID_EX_wb_ctlout,
  input  logic [2:0]       ID_EX_m_ctlout,
  input  logic             ID_EX_reg_dst,
  input  logic [1:0]       ID_EX_alu_op,
  input  logic             ID_EX_alu_src,
  input  logic             ex_flush,
  output logic             ex_stall,
  output logic [1:0]       EX_MEM_wb_ctlout,
  output logic [2:0]       EX_MEM_m_ctlout,
  output logic [WIDTH-1:0] EX_MEM_add_result,
  output logic             EX_MEM_zero,
  output logic [WIDTH-1:0] EX_MEM_alu_result,
  output logic [WIDTH-1:0] EX_MEM_rdata2,
  output logic [4:0]       EX_MEM_five_bit_muxout
);

  alu_ctl_e         w_ctl;
  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0] w_target;
  logic [4:0]       w_dst;
  logic             w_busy;
  logic             w_done;

  assign w_ctl    = alu_ctl(ID_EX_alu_op, ID_EX_sign_ext[5:0]);
  assign w_alu_b  = ID_EX_alu_src ? ID_EX_sign_ext : ID_EX_rdata2;
  assign w_dst    = ID_EX_reg_dst ? ID_EX_instr_1511
                                  : ID_EX_instr_2016;
  assign w_target = ID_EX_npc + (ID_EX_sign_ext << 2);
  assign ex_stall = w_busy;

  mul_unit #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_ctl == ALU_MUL),
    .i_flush (ex_flush),
    .i_a     (ID_EX_rdata1),
    .i_b     (w_alu_b),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_result(w_mul_res)
  );

  // ALU result select.
  always_comb begin
    w_res = '0;
    unique case (w_ctl)
      ALU_ADD: w_res = ID_EX_rdata1 + w_alu_b;
      ALU_SUB: w_res = ID_EX_rdata1 - w_alu_b;
      ALU_AND: w_res = ID_EX_rdata1 & w_alu_b;
      ALU_OR:  w_res = ID_EX_rdata1 | w_alu_b;
      ALU_SLT: w_res = {{(WIDTH-1){1'b0}},
                        $signed(ID_EX_rdata1) < $signed(w_alu_b)};
      ALU_MUL: w_res = w_done ? w_mul_res : '0;
      default: w_res = '0;
    endcase
  end

  // EX/MEM latch: flush/stall insert a control bubble, data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_MEM_wb_ctlout       <= '0;
      EX_MEM_m_ctlout        <= '0;
      EX_MEM_add_result      <= '0;
      EX_MEM_zero            <= 1'b0;
      EX_MEM_alu_result      <= '0;
      EX_MEM_rdata2          <= '0;
      EX_MEM_five_bit_muxout <= '0;
    end else if (ex_flush || ex_stall) begin
      EX_MEM_wb_ctlout <= '0;
      EX_MEM_m_ctlout  <= '0;
    end else begin
      EX_MEM_wb_ctlout       <= ID_EX_wb_ctlout;
      EX_MEM_m_ctlout        <= ID_EX_m_ctlout;
      EX_MEM_add_result      <= w_target;
      EX_MEM_zero            <= (w_res == '0);
      EX_MEM_alu_result      <= w_res;
      EX_MEM_rdata2          <= ID_EX_rdata2;
      EX_MEM_five_bit_muxout <= w_dst;
    end
  end

endmodule
